// File: rtl/card_dealer_if.sv
// Request/response bundle between the card dealer and its controller
// (game FSM / MIPS I/O side).
interface card_dealer_if;
    logic        seed_load;
    logic [31:0] seed_in;
    logic        shuffle;
    logic        deal_req;
    logic        deal_ready;
    logic        card_valid;
    logic [5:0]  card;
    logic [3:0]  rank;
    logic [1:0]  suit;
    logic [5:0]  cards_left;
    logic        deck_empty;

    modport master (
        output seed_load, seed_in, shuffle, deal_req,
        input  deal_ready, card_valid, card, rank, suit, cards_left, deck_empty
    );

    modport slave (
        input  seed_load, seed_in, shuffle, deal_req,
        output deal_ready, card_valid, card, rank, suit, cards_left, deck_empty
    );
endinterface

// File: rtl/card_dealer.sv
// Deals unique cards from a 52-card deck: xorshift32 draw, bit-serial mod 52,
// then linear probing of the dealt mask until a free slot is found.
module card_dealer #(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input logic        clock,
    input logic        reset,
    card_dealer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, STEP, REDUCE, PROBE, EMIT} state_t;

    state_t      state, state_nx;
    logic [31:0] rng, shreg;
    logic [5:0]  rem, cnt, idx;
    logic [51:0] mask;
    logic [5:0]  card, cards_left;
    logic [3:0]  rank;
    logic [1:0]  suit;

    function automatic logic [31:0] xorshift(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    logic [31:0] rng_nx;
    logic [6:0]  t;
    logic [5:0]  rem_nx, idx_wrap, base, rank_full;
    logic [1:0]  suit_nx;

    always_comb begin
        rng_nx   = xorshift(rng);
        t        = {rem, shreg[31]};
        rem_nx   = (t >= 7'd52) ? 6'(t - 7'd52) : t[5:0];
        idx_wrap = (idx == 6'd51) ? 6'd0 : idx + 6'd1;
        if (idx >= 6'd39)      suit_nx = 2'd3;
        else if (idx >= 6'd26) suit_nx = 2'd2;
        else if (idx >= 6'd13) suit_nx = 2'd1;
        else                   suit_nx = 2'd0;
        base      = 6'(suit_nx) * 6'd13;
        rank_full = idx - base + 6'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.shuffle) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.deal_req && bus.deal_ready) state_nx = STEP;
                STEP:    state_nx = REDUCE;
                REDUCE:  if (cnt == 6'd1) state_nx = PROBE;
                PROBE:   if (!mask[idx]) state_nx = EMIT;
                EMIT:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rng        <= SEED;
            shreg      <= '0;
            rem        <= '0;
            cnt        <= '0;
            idx        <= '0;
            mask       <= '0;
            card       <= '0;
            rank       <= '0;
            suit       <= '0;
            cards_left <= 6'd52;
        end else begin
            // A running deal already copied its draw into shreg, so reseeding
            // mid-deal only affects the next request.
            if (bus.seed_load)
                rng <= (bus.seed_in == 32'd0) ? SEED : bus.seed_in;
            else if (!bus.shuffle && state == STEP)
                rng <= rng_nx;

            if (bus.shuffle) begin
                mask       <= '0;
                cards_left <= 6'd52;
            end else begin
                case (state)
                    STEP: begin
                        shreg <= rng_nx;
                        rem   <= '0;
                        cnt   <= 6'd32;
                    end
                    REDUCE: begin
                        rem   <= rem_nx;
                        idx   <= rem_nx;
                        shreg <= shreg << 1;
                        cnt   <= cnt - 6'd1;
                    end
                    PROBE: begin
                        if (mask[idx]) begin
                            idx <= idx_wrap;
                        end else begin
                            mask[idx]  <= 1'b1;
                            cards_left <= cards_left - 6'd1;
                            card       <= idx + 6'd1;
                            rank       <= rank_full[3:0];
                            suit       <= suit_nx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.deck_empty = (cards_left == 6'd0);
    assign bus.deal_ready = (state == IDLE) && (cards_left != 6'd0);
    assign bus.card_valid = (state == EMIT);
    assign bus.card       = card;
    assign bus.rank       = rank;
    assign bus.suit       = suit;
    assign bus.cards_left = cards_left;
endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a reference deck model queues the expected
// card and latency of every accepted request.
module tb_card_dealer;
    logic clock = 1'b0;
    logic reset;
    card_dealer_if bus ();

    card_dealer #(.SEED(32'h0000_0001)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0] card;
        logic [3:0] rank;
        logic [1:0] suit;
        logic [5:0] left;
        logic [7:0] lat;
    } res_t;

    res_t        q[$];
    logic [31:0] rng_m;
    logic [51:0] mask_m;
    int          left_m;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    task automatic model_accept();
        int i, n;
        res_t e;
        rng_m = xs32(rng_m);
        i = int'(rng_m % 52);
        n = 0;
        while (mask_m[i]) begin
            i = (i + 1) % 52;
            n++;
        end
        mask_m[i] = 1'b1;
        left_m--;
        e.card = 6'(i + 1);
        e.rank = 4'(i % 13 + 1);
        e.suit = 2'(i / 13);
        e.left = 6'(left_m);
        e.lat  = 8'(35 + n);
        q.push_back(e);
    endtask

    task automatic do_reset();
        bus.seed_load = 0; bus.seed_in = 0; bus.shuffle = 0; bus.deal_req = 0;
        reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        rng_m = 32'd1; mask_m = '0; left_m = 52; q.delete();
    endtask

    task automatic do_shuffle();
        bus.shuffle = 1;
        @(negedge clock);
        bus.shuffle = 0;
        mask_m = '0; left_m = 52;
    endtask

    task automatic do_seed(input logic [31:0] s);
        bus.seed_load = 1; bus.seed_in = s;
        @(negedge clock);
        bus.seed_load = 0;
        rng_m = (s == 32'd0) ? 32'd1 : s;
    endtask

    // Drives one request and returns what the DUT emitted; lat 8'hFE/8'hFF flag timeouts.
    task automatic deal(output res_t o);
        int w, lat;
        o = '0;
        w = 0;
        while (!bus.deal_ready && w < 20) begin @(negedge clock); w++; end
        if (!bus.deal_ready) begin o.lat = 8'hFE; return; end
        model_accept();
        bus.deal_req = 1;
        @(negedge clock);
        bus.deal_req = 0;
        lat = 1;
        while (!bus.card_valid && lat < 200) begin @(negedge clock); lat++; end
        if (!bus.card_valid) begin o.lat = 8'hFF; return; end
        o.card = bus.card; o.rank = bus.rank; o.suit = bus.suit;
        o.left = bus.cards_left; o.lat = 8'(lat);
    endtask

    task automatic pop_exp(output res_t e);
        if (q.size() != 0) e = q.pop_front();
        else               e = '1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.card_valid, bus.card, bus.rank, bus.suit, bus.cards_left, bus.deck_empty, bus.deal_ready}
            !== {1'b0, 6'd0, 4'd0, 2'd0, 6'd52, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset: valid=%0b card=%0d rank=%0d suit=%0d left=%0d empty=%0b ready=%0b, required 0/0/0/0/52/0/1",
                     bus.card_valid, bus.card, bus.rank, bus.suit, bus.cards_left, bus.deck_empty, bus.deal_ready);
        end
    endtask

    task automatic test_first_card();
        res_t o, e;
        deal(o);
        pop_exp(e);
        n_cmp++;
        if (o !== res_t'{6'd22, 4'd9, 2'd1, 6'd51, 8'd35}) begin
            n_bad++;
            $display("FAIL first_card: got card=%0d rank=%0d suit=%0d left=%0d lat=%0d, required 22/9/1/51/35",
                     o.card, o.rank, o.suit, o.left, o.lat);
        end
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL first_card_model: got %h required %h", o, e);
        end
    endtask

    task automatic test_collision();
        res_t o, e;
        do_shuffle();
        do_seed(32'd1);
        deal(o); pop_exp(e);
        n_cmp++;
        if (o !== e || o.card !== 6'd22) begin
            n_bad++;
            $display("FAIL collision_first: got %h required %h (card 22)", o, e);
        end
        do_seed(32'd1);
        deal(o); pop_exp(e);
        n_cmp++;
        if (o !== res_t'{6'd23, 4'd10, 2'd1, 6'd50, 8'd36} || o !== e) begin
            n_bad++;
            $display("FAIL collision_probe: got card=%0d lat=%0d left=%0d, required card=23 lat=36 left=50",
                     o.card, o.lat, o.left);
        end
    endtask

    task automatic test_wrap();
        res_t o, e;
        logic [31:0] s;
        s = 32'd2;
        while (xs32(s) % 52 != 51 && s < 32'd100000) s++;
        do_shuffle();
        do_seed(s);
        deal(o); pop_exp(e);
        n_cmp++;
        if (o !== res_t'{6'd52, 4'd13, 2'd3, 6'd51, 8'd35} || o !== e) begin
            n_bad++;
            $display("FAIL wrap_last_slot: got %h, required card=52 rank=13 suit=3 left=51 lat=35", o);
        end
        do_seed(s);
        deal(o); pop_exp(e);
        n_cmp++;
        if (o !== res_t'{6'd1, 4'd1, 2'd0, 6'd50, 8'd36} || o !== e) begin
            n_bad++;
            $display("FAIL wrap_to_zero: got card=%0d lat=%0d left=%0d, required card=1 lat=36 left=50",
                     o.card, o.lat, o.left);
        end
    endtask

    task automatic test_shuffle_mid();
        int pulses;
        bus.deal_req = 1;
        @(negedge clock);
        bus.deal_req = 0;
        rng_m = xs32(rng_m);
        repeat (10) @(negedge clock);
        bus.shuffle = 1;
        @(negedge clock);
        bus.shuffle = 0;
        mask_m = '0; left_m = 52;
        n_cmp++;
        if (bus.deal_ready !== 1'b1 || bus.cards_left !== 6'd52) begin
            n_bad++;
            $display("FAIL shuffle_mid_state: ready=%0b left=%0d, required ready=1 left=52",
                     bus.deal_ready, bus.cards_left);
        end
        pulses = 0;
        repeat (60) begin
            if (bus.card_valid) pulses++;
            @(negedge clock);
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL shuffle_mid_pulse: %0d card_valid pulses, required 0", pulses);
        end
    endtask

    task automatic test_zero_seed();
        res_t o, e;
        do_shuffle();
        do_seed(32'd0);
        deal(o); pop_exp(e);
        n_cmp++;
        if (o !== res_t'{6'd22, 4'd9, 2'd1, 6'd51, 8'd35} || o !== e) begin
            n_bad++;
            $display("FAIL zero_seed: got card=%0d lat=%0d, required card=22 lat=35", o.card, o.lat);
        end
    endtask

    task automatic test_back_to_back();
        res_t o, e;
        logic [52:1] seen;
        int bad_deals, pulses;
        do_reset();
        seen = '0;
        bad_deals = 0;
        for (int k = 0; k < 52; k++) begin
            deal(o); pop_exp(e);
            if (o !== e || o.card < 6'd1 || o.card > 6'd52 || seen[o.card]) begin
                bad_deals++;
                if (bad_deals <= 4)
                    $display("FAIL b2b_deal_%0d: got %h required %h", k, o, e);
            end else begin
                seen[o.card] = 1'b1;
            end
        end
        n_cmp++;
        if (bad_deals !== 0 || seen !== {52{1'b1}}) begin
            n_bad++;
            $display("FAIL b2b_deck: %0d bad deals, seen=%h required all 52 once", bad_deals, seen);
        end
        @(negedge clock);
        n_cmp++;
        if (bus.deck_empty !== 1'b1 || bus.deal_ready !== 1'b0 || bus.cards_left !== 6'd0) begin
            n_bad++;
            $display("FAIL b2b_empty: empty=%0b ready=%0b left=%0d, required 1/0/0",
                     bus.deck_empty, bus.deal_ready, bus.cards_left);
        end
        pulses = 0;
        bus.deal_req = 1;
        repeat (100) begin
            @(negedge clock);
            if (bus.card_valid) pulses++;
        end
        bus.deal_req = 0;
        n_cmp++;
        if (pulses !== 0 || bus.deal_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_extra_req: %0d pulses ready=%0b, required 0 pulses ready=0",
                     pulses, bus.deal_ready);
        end
    endtask

    initial begin
        reset = 1;
        bus.seed_load = 0; bus.seed_in = 0; bus.shuffle = 0; bus.deal_req = 0;
        @(negedge clock);
        test_reset();
        test_first_card();
        test_collision();
        test_wrap();
        test_shuffle_mid();
        test_zero_seed();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
